// File: rtl/wfg_wb_master.sv
// Wishbone classic initiator: one command in, one read or write bus cycle, one response out.
// Optional ack timeout is compiled in when WFG_WB_MASTER_TIMEOUT_EN is defined.
module wfg_wb_master #(
    parameter int unsigned BUSW           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [BUSW-1:0]   cmd_adr_i,
    input  logic [BUSW-1:0]   cmd_dat_i,
    input  logic [BUSW/8-1:0] cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BUSW-1:0]   rsp_dat_o,
    output logic              rsp_err_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [BUSW/8-1:0] wbm_sel_o,
    output logic [BUSW-1:0]   wbm_adr_o,
    output logic [BUSW-1:0]   wbm_dat_o,
    input  logic [BUSW-1:0]   wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic   accept;
    logic   ack_done;
    logic   rsp_done;
    logic   timeout_hit;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wfg_wb_master: TIMEOUT_CYCLES must be at least 1");
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack takes priority over a timeout that expires on the same edge.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_done   = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    ack_done   = 1'b1;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    // Address, data, select and we stay at their last value between transfers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            if (accept) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
            end
            if (ack_done || timeout_hit) begin
                wbm_cyc_o   <= 1'b0;
                wbm_stb_o   <= 1'b0;
                rsp_valid_o <= 1'b1;
                rsp_dat_o   <= (ack_done && !wbm_we_o) ? wbm_dat_i : '0;
            end
            if (rsp_done) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

`ifdef WFG_WB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;

    // The limit is hit on the edge that would bring the count to TIMEOUT_CYCLES.
    assign timeout_hit = (state == BUS) && !wbm_ack_i && (wait_cnt == CNT_LAST);
    assign rsp_err_o   = rsp_err_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wait_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= '0;
            end else if ((state == BUS) && !wbm_ack_i) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (ack_done || timeout_hit) begin
                rsp_err_q <= timeout_hit;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wfg_wb_master.sv
// Self-checking bench for wfg_wb_master: vector table, corner-case sequences and random
// transfers against a word-memory reference model.
module tb_wfg_wb_master;

    localparam int TO_CYCLES = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        busy_o;

    wfg_wb_master #(
        .BUSW           (32),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy_o      (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc_count = 0;
    always @(posedge wb_clk_i) cyc_count <= cyc_count + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        logic [31:0] adr;
        logic [31:0] dat;
    } log_t;
    log_t bus_log[$];

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    int          slave_wait      = 0;
    bit          slave_never_ack = 1'b0;
    bit          stray_ack       = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        if (slave_mem.exists(a)) return slave_mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Slave: acks on the (slave_wait+1)-th strobe cycle; read data is junk except while acking.
    initial begin
        int stb_cnt;
        stb_cnt = 0;
        forever begin
            @(negedge wb_clk_i);
            wbm_dat_i = $urandom;
            if (wbm_cyc_o && wbm_stb_o) begin
                stb_cnt++;
                if (stb_cnt == 1) bus_log.push_back('{cyc_count, wbm_adr_o, wbm_dat_o});
                if (!slave_never_ack && stb_cnt == slave_wait + 1) begin
                    wbm_ack_i = 1'b1;
                    if (wbm_we_o) begin
                        slave_mem[wbm_adr_o] = merge(slave_read(wbm_adr_o), wbm_dat_o, wbm_sel_o);
                    end else begin
                        wbm_dat_i = slave_read(wbm_adr_o);
                    end
                end else begin
                    wbm_ack_i = 1'b0;
                end
            end else begin
                stb_cnt   = 0;
                wbm_ack_i = stray_ack;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer starting from IDLE, called just after a falling edge.
    task automatic apply_stimulus(
        input  logic        we,
        input  logic [31:0] adr,
        input  logic [31:0] dat,
        input  logic [3:0]  sel,
        input  int          wait_cyc,
        input  int          rdy_delay,
        output logic [31:0] rd,
        output logic        err,
        output int          stb_len,
        output int          lat
    );
        logic stable_ok;
        slave_wait  = wait_cyc;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        check_output("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        cmd_we_i    = ~we;
        cmd_adr_i   = $urandom;
        cmd_dat_i   = $urandom;
        cmd_sel_i   = ~sel;
        stb_len     = 0;
        lat         = 1;
        rd          = '0;
        err         = 1'b1;
        while (!rsp_valid_o && lat < 400) begin
            if (wbm_stb_o) begin
                if (stb_len == 0) begin
                    check_output("bus_adr", wbm_adr_o, adr);
                    check_output("bus_we_sel", 32'({wbm_cyc_o, wbm_we_o, wbm_sel_o}),
                                 32'({1'b1, we, sel}));
                    if (we) check_output("bus_dat", wbm_dat_o, dat);
                end
                stb_len++;
            end
            @(negedge wb_clk_i);
            lat++;
        end
        check_output("rsp_valid_seen", 32'(rsp_valid_o), 32'd1);
        if (!rsp_valid_o) return;
        check_output("cyc_stb_dropped", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
        rd        = rsp_dat_o;
        err       = rsp_err_o;
        stable_ok = 1'b1;
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge wb_clk_i);
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== rd || rsp_err_o !== err ||
                cmd_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0 || busy_o !== 1'b1) stable_ok = 1'b0;
        end
        if (rdy_delay > 0) check_output("rsp_hold", 32'(stable_ok), 32'd1);
        rsp_ready_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        check_output("rsp_released", 32'({rsp_valid_o, cmd_ready_o, busy_o}), 32'b010);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          wait_cyc;
        int          rdy_delay;
        logic [31:0] exp_dat;
        int          exp_stb;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] rd, adr, dat, exp;
    logic        err, we;
    logic [3:0]  sel;
    int          stb_len, lat, wt, k;

    initial begin
        vecs[0] = '{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0000_0000, 1};
        vecs[1] = '{1'b0, 32'h08, 32'h0000_0000, 4'hF, 3, 0, 32'h0000_00A5, 4};
        vecs[2] = '{1'b0, 32'h04, 32'h0000_0000, 4'hF, 1, 1, 32'hDEAD_BEEF, 2};
        vecs[3] = '{1'b1, 32'h04, 32'h1234_5678, 4'h3, 2, 0, 32'h0000_0000, 3};
        vecs[4] = '{1'b0, 32'h04, 32'h0000_0000, 4'hF, 0, 2, 32'hDEAD_5678, 1};
        vecs[5] = '{1'b0, 32'h20, 32'h0000_0000, 4'hF, 0, 0, 32'h5A5A_0020, 1};
        slave_mem[32'h08] = 32'h0000_00A5;
        model_mem[32'h08] = 32'h0000_00A5;

        // Reset state
        repeat (3) @(negedge wb_clk_i);
        check_output("reset_ctrl", 32'({cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                                         rsp_valid_o, rsp_err_o, busy_o}), 32'b1000000);
        check_output("reset_adr", wbm_adr_o, 32'h0);
        check_output("reset_dat", wbm_dat_o ^ rsp_dat_o, 32'h0);
        check_output("reset_sel", 32'(wbm_sel_o), 32'h0);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                           vecs[i].wait_cyc, vecs[i].rdy_delay, rd, err, stb_len, lat);
            if (vecs[i].we) model_mem[vecs[i].adr] = merge(model_read(vecs[i].adr),
                                                           vecs[i].dat, vecs[i].sel);
            check_output($sformatf("vec%0d_rsp_dat", i), rd, vecs[i].exp_dat);
            check_output($sformatf("vec%0d_rsp_err", i), 32'(err), 32'd0);
            check_output($sformatf("vec%0d_stb_len", i), 32'(stb_len), 32'(vecs[i].exp_stb));
            check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].wait_cyc + 2));
        end

        // Back-to-back writes with the response consumer always ready
        bus_log.delete();
        slave_wait  = 0;
        rsp_ready_i = 1'b1;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (cmd_ready_o && k < 4) begin
                cmd_valid_i = 1'b1;
                cmd_we_i    = 1'b1;
                cmd_adr_i   = 32'h40 + 32'(4 * k);
                cmd_dat_i   = 32'hC0DE_0000 + 32'(k);
                cmd_sel_i   = 4'hF;
                model_mem[cmd_adr_i] = cmd_dat_i;
                k++;
            end else begin
                cmd_valid_i = (k < 4);
                cmd_we_i    = 1'b0;
                cmd_adr_i   = $urandom;
                cmd_dat_i   = $urandom;
            end
            @(negedge wb_clk_i);
        end
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        check_output("b2b_count", 32'(bus_log.size()), 32'd4);
        for (int i = 0; i < bus_log.size() && i < 4; i++) begin
            check_output($sformatf("b2b%0d_adr", i), bus_log[i].adr, 32'h40 + 32'(4 * i));
            check_output($sformatf("b2b%0d_dat", i), bus_log[i].dat, 32'hC0DE_0000 + 32'(i));
            if (i > 0) check_output($sformatf("b2b%0d_spacing", i),
                                    32'(bus_log[i].cyc - bus_log[i-1].cyc), 32'd3);
        end

        // Backpressure on a read, with stray acks while idle and while holding the response
        stray_ack = 1'b1;
        bus_log.delete();
        apply_stimulus(1'b0, 32'h44, 32'h0, 4'hF, 1, 10, rd, err, stb_len, lat);
        check_output("bp_rsp_dat", rd, model_read(32'h44));
        check_output("bp_stb_len", 32'(stb_len), 32'd2);
        check_output("bp_bus_count", 32'(bus_log.size()), 32'd1);
        repeat (3) @(negedge wb_clk_i);
        check_output("stray_ack_idle", 32'({busy_o, rsp_valid_o, wbm_cyc_o, cmd_ready_o}), 32'b0001);
        stray_ack = 1'b0;
        repeat (2) @(negedge wb_clk_i);

`ifdef WFG_WB_MASTER_TIMEOUT_EN
        // Slave that never acks, then one that acks on the last allowed cycle
        slave_never_ack = 1'b1;
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, 0, rd, err, stb_len, lat);
        check_output("to_rsp_dat", rd, 32'h0);
        check_output("to_rsp_err", 32'(err), 32'd1);
        check_output("to_stb_len", 32'(stb_len), 32'(TO_CYCLES));
        slave_never_ack = 1'b0;
        apply_stimulus(1'b0, 32'h08, 32'h0, 4'hF, TO_CYCLES - 1, 0, rd, err, stb_len, lat);
        check_output("to_edge_dat", rd, 32'h0000_00A5);
        check_output("to_edge_err", 32'(err), 32'd0);
        check_output("to_edge_stb_len", 32'(stb_len), 32'(TO_CYCLES));
`endif

        // Asynchronous reset in the middle of a bus cycle
        slave_never_ack = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h30;
        cmd_sel_i   = 4'hF;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        check_output("mid_bus_active", 32'({wbm_cyc_o, wbm_stb_o, busy_o}), 32'b111);
        #2 wb_rst_ni = 1'b0;
        #1 check_output("async_reset", 32'({wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o, cmd_ready_o}),
                        32'b00001);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        slave_never_ack = 1'b0;
        @(negedge wb_clk_i);
        apply_stimulus(1'b0, 32'h04, 32'h0, 4'hF, 1, 0, rd, err, stb_len, lat);
        check_output("post_reset_dat", rd, model_read(32'h04));
        check_output("post_reset_stb", 32'(stb_len), 32'd2);

        // Random transfers against the memory model
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom_range(0, 1));
            adr = 32'($urandom_range(0, 15)) * 32'd4;
            dat = $urandom;
            sel = 4'($urandom_range(1, 15));
            wt  = int'($urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
            exp = we ? 32'h0 : model_read(adr);
            apply_stimulus(we, adr, dat, sel, wt, int'($urandom_range(0, 2)), rd, err, stb_len, lat);
            if (we) model_mem[adr] = merge(model_read(adr), dat, sel);
            check_output($sformatf("rnd%0d_rsp_dat", i), rd, exp);
            check_output($sformatf("rnd%0d_rsp_err", i), 32'(err), 32'd0);
            check_output($sformatf("rnd%0d_stb_len", i), 32'(stb_len), 32'(wt + 1));
            check_output($sformatf("rnd%0d_latency", i), 32'(lat), 32'(wt + 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
